// File: rtl/flopr_wr_arbiter_pkg.sv
// Shared definitions for the round-robin write arbiter: FSM encoding and default sizes.
package flopr_wr_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StBusy   = 2'd1,
    StLocked = 2'd2
  } state_e;

  localparam int unsigned DefaultN = 4;
  localparam int unsigned DefaultW = 4;

endpackage

// File: rtl/flopr_en.sv
// W-bit register with load enable; synchronous active-high reset wins over the enable.
module flopr_en #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         En,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (En) begin
      q <= d;
    end
  end

endmodule

// File: rtl/flopr_wr_arbiter.sv
// Round-robin arbiter granting one of N requesters write access to a shared enabled register,
// with an owner lock for back-to-back writes.
module flopr_wr_arbiter
  import flopr_wr_arbiter_pkg::*;
#(
  parameter int unsigned N = DefaultN,
  parameter int unsigned W = DefaultW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         lock,
  input  logic [N*W-1:0]       wdata,
  output logic [N-1:0]         ack,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] owner,
  output logic                 wr_en,
  output logic [W-1:0]         q
);

  localparam int unsigned OW = $clog2(N);

  state_e        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] ptr_q, ptr_d;
  logic [OW-1:0] ptr_next;
  logic [N-1:0]  others;
  logic [W-1:0]  wdata_arr [N];

  // First set bit of cand scanning upward from start; N is a power of two so the index wraps.
  function automatic logic [OW-1:0] rr_pick(input logic [N-1:0] cand, input logic [OW-1:0] start);
    logic [OW-1:0] idx;
    logic [OW-1:0] win;
    logic          found;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = start + OW'(i);
      if (!found && cand[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [OW-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign wdata_arr[i] = wdata[i*W +: W];
  end

  always_comb begin
    ack = '0;
    if (!reset && state_q != StIdle) begin
      ack = req & grant_q;
    end
  end

  assign wr_en = |ack;
  assign grant = grant_q;
  assign owner = owner_q;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    ptr_next = owner_q + OW'(1);
    // The owner is excluded from the next round even if it still requests.
    others   = req & ~grant_q;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          owner_d = rr_pick(req, ptr_q);
          grant_d = onehot(owner_d);
          state_d = StBusy;
        end
      end
      StBusy, StLocked: begin
        if (lock[owner_q]) begin
          state_d = StLocked;
        end else begin
          ptr_d = ptr_next;
          if (|others) begin
            owner_d = rr_pick(others, ptr_next);
            grant_d = onehot(owner_d);
            state_d = StBusy;
          end else begin
            owner_d = '0;
            grant_d = '0;
            state_d = StIdle;
          end
        end
      end
      default: begin
        owner_d = '0;
        grant_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  flopr_en #(
    .W(W)
  ) u_reg (
    .clk  (clk),
    .reset(reset),
    .En   (wr_en),
    .d    (wdata_arr[owner_q]),
    .q    (q)
  );

endmodule

// File: tb/tb_flopr_wr_arbiter.sv
// Self-checking bench for flopr_wr_arbiter: directed scenarios plus randomized traffic
// compared against an integer-level reference model.
module tb_flopr_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int OW = $clog2(N);

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N-1:0]   lock;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   ack;
  logic [N-1:0]   grant;
  logic [OW-1:0]  owner;
  logic           wr_en;
  logic [W-1:0]   q;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: owner index (-1 when idle), round-robin start point, register value.
  int         m_owner = -1;
  int         m_ptr   = 0;
  logic [W-1:0] m_q   = '0;

  flopr_wr_arbiter #(
    .N(N),
    .W(W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .req  (req),
    .lock (lock),
    .wdata(wdata),
    .ack  (ack),
    .grant(grant),
    .owner(owner),
    .wr_en(wr_en),
    .q    (q)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++) begin
      if (v[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_grant();
    logic [N-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  function automatic logic [N-1:0] m_ack();
    if (reset || m_owner < 0) return '0;
    return req[m_owner] ? m_grant() : '0;
  endfunction

  function automatic logic [OW-1:0] m_own();
    return (m_owner < 0) ? '0 : OW'(m_owner);
  endfunction

  // Advance one clock: model next state from the current inputs, then let the DUT take the edge.
  task automatic clock_edge();
    int           nxt_owner = m_owner;
    int           nxt_ptr   = m_ptr;
    logic [W-1:0] nxt_q     = m_q;
    logic [N-1:0] oth;
    if (reset) begin
      nxt_owner = -1;
      nxt_ptr   = 0;
      nxt_q     = '0;
    end else if (m_owner < 0) begin
      if (req != 0) nxt_owner = pick(req, m_ptr);
    end else begin
      if (req[m_owner]) nxt_q = wdata[m_owner*W +: W];
      if (!lock[m_owner]) begin
        nxt_ptr        = (m_owner + 1) % N;
        oth            = req;
        oth[m_owner]   = 1'b0;
        nxt_owner      = (oth != 0) ? pick(oth, nxt_ptr) : -1;
      end
    end
    @(posedge clk);
    #1;
    m_owner = nxt_owner;
    m_ptr   = nxt_ptr;
    m_q     = nxt_q;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    lock  = '0;
    wdata = '0;
    clock_edge();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 4'b1111;
    lock  = '0;
    wdata = 16'h4321;
    clock_edge();
    clock_edge();
    #1;
    n_checks++;
    if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", grant); end
    n_checks++;
    if (ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack: got %b want 0000", ack); end
    n_checks++;
    if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
    n_checks++;
    if (q !== 4'h0) begin n_fail++; $display("FAIL reset_q: got %h want 0", q); end
    reset = 1'b0;
    clock_edge();
    n_checks++;
    if (grant !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant: got %b want 0001", grant); end
    req = '0;
    clock_edge();
  endtask

  task automatic test_single();
    do_reset();
    req           = 4'b0100;
    wdata[2*W +: W] = 4'b1011;
    #1;
    n_checks++;
    if (ack !== 4'b0000) begin n_fail++; $display("FAIL single_idle_ack: got %b want 0000", ack); end
    clock_edge();
    n_checks++;
    if (grant !== 4'b0100 || ack !== 4'b0100 || wr_en !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant: got grant=%b ack=%b wr_en=%b want 0100 0100 1", grant, ack, wr_en);
    end
    clock_edge();
    req = '0;
    #1;
    n_checks++;
    if (q !== 4'b1011 || grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_write: got q=%b grant=%b want 1011 0000", q, grant);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < N; i++) wdata[i*W +: W] = W'(i + 1);
    clock_edge();
    for (int k = 0; k < N; k++) begin
      #1;
      n_checks++;
      if (grant !== 4'(1 << k) || ack !== 4'(1 << k)) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got grant=%b ack=%b want %b", k, grant, ack, 4'(1 << k));
      end
      clock_edge();
      req[k] = 1'b0;
      #1;
      n_checks++;
      if (q !== W'(k + 1)) begin n_fail++; $display("FAIL rr_q%0d: got %h want %h", k, q, W'(k + 1)); end
    end
    n_checks++;
    if (grant !== 4'b0000) begin n_fail++; $display("FAIL rr_idle: got grant=%b want 0000", grant); end
  endtask

  task automatic test_lock();
    logic [W-1:0] vals [3] = '{4'hA, 4'hB, 4'hC};
    do_reset();
    req             = 4'b0011;
    lock            = 4'b0001;
    wdata[1*W +: W] = 4'h7;
    clock_edge();
    for (int j = 0; j < 3; j++) begin
      wdata[0 +: W] = vals[j];
      #1;
      n_checks++;
      if (ack !== 4'b0001 || grant !== 4'b0001) begin
        n_fail++;
        $display("FAIL lock_ack%0d: got ack=%b grant=%b want 0001 0001", j, ack, grant);
      end
      clock_edge();
      n_checks++;
      if (q !== vals[j]) begin n_fail++; $display("FAIL lock_q%0d: got %h want %h", j, q, vals[j]); end
    end
    lock          = 4'b0000;
    wdata[0 +: W] = 4'hD;
    #1;
    n_checks++;
    if (ack !== 4'b0001) begin n_fail++; $display("FAIL lock_release_ack: got %b want 0001", ack); end
    clock_edge();
    req[0] = 1'b0;
    #1;
    n_checks++;
    if (q !== 4'hD || grant !== 4'b0010 || ack !== 4'b0010) begin
      n_fail++;
      $display("FAIL lock_handover: got q=%h grant=%b ack=%b want d 0010 0010", q, grant, ack);
    end
    clock_edge();
    req = '0;
    n_checks++;
    if (q !== 4'h7) begin n_fail++; $display("FAIL lock_next_q: got %h want 7", q); end
    clock_edge();
  endtask

  task automatic test_locked_idle();
    do_reset();
    req           = 4'b0101;
    lock          = 4'b0001;
    wdata[0 +: W] = 4'h5;
    wdata[2*W +: W] = 4'h9;
    clock_edge();
    clock_edge();
    req[0] = 1'b0;
    repeat (4) begin
      #1;
      n_checks++;
      if (wr_en !== 1'b0 || grant !== 4'b0001 || q !== 4'h5) begin
        n_fail++;
        $display("FAIL locked_idle_hold: got wr_en=%b grant=%b q=%h want 0 0001 5", wr_en, grant, q);
      end
      clock_edge();
    end
    lock = '0;
    clock_edge();
    n_checks++;
    if (grant !== 4'b0100) begin n_fail++; $display("FAIL locked_idle_release: got %b want 0100", grant); end
    req = '0;
    clock_edge();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req             = 4'b0011;
    wdata[0 +: W]   = 4'h3;
    wdata[1*W +: W] = 4'hF;
    clock_edge();
    clock_edge();
    req[0] = 1'b0;
    #1;
    n_checks++;
    if (ack !== 4'b0010 || q !== 4'h3) begin
      n_fail++;
      $display("FAIL mid_setup: got ack=%b q=%h want 0010 3", ack, q);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (ack !== 4'b0000 || wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_ack_gated: got ack=%b wr_en=%b want 0000 0", ack, wr_en);
    end
    clock_edge();
    reset = 1'b0;
    req   = '0;
    n_checks++;
    if (q !== 4'h0 || grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_reset: got q=%h grant=%b want 0 0000", q, grant);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] a;
    logic [N-1:0] eg;
    logic [N-1:0] ea;
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 59) == 0);
      lock  = N'($urandom_range(0, 15) & $urandom_range(0, 15));
      #1;
      eg = m_grant();
      ea = m_ack();
      n_checks++;
      if ({grant, ack, owner, wr_en, q} !== {eg, ea, m_own(), (ea != 0), m_q}) begin
        n_fail++;
        $display("FAIL random_cyc%0d: got g=%b a=%b o=%0d w=%b q=%h want g=%b a=%b o=%0d w=%b q=%h",
                 c, grant, ack, owner, wr_en, q, eg, ea, m_own(), (ea != 0), m_q);
      end
      a = ea;
      clock_edge();
      for (int i = 0; i < N; i++) begin
        if (a[i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
          else wdata[i*W +: W] = W'($urandom);
        end else if (!req[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            req[i]           = 1'b1;
            wdata[i*W +: W]  = W'($urandom);
          end
        end else if ($urandom_range(0, 19) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    lock  = '0;
    wdata = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_locked_idle();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/flopr_wr_arbiter.md
Name: flopr_wr_arbiter

Overview:
- Round-robin write arbiter sharing one enabled W-bit register (flopr-style: synchronous reset, load enable) among N requesters.
- Each requester presents data with a req/ack handshake.
- The arbiter selects one owner, drives the register enable and data, and supports a lock so one owner can keep the register for back-to-back writes.
- Sits between the requesting datapath units and the shared register; q is the register's output.

Parameters:
- N, 4, number of requesters (≥2, power of two)
- W, 4, register/data width
- OW, $clog2(N), owner index width (derived localparam, not overridable)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req  input  N  per-requester write request; held with stable data until ack
- lock  input  N  per-requester lock; sampled only for current owner
- wdata  input  N*W  requester i data at [i*W +: W]
- ack  output  N  one-hot; ack[i]=1 means the write of requester i happens at this clock edge
- grant  output  N  registered one-hot current owner; 0 when idle
- owner  output  OW  binary index of grant (0 when idle)
- wr_en  output  1  register load enable this cycle (= |ack)
- q  output  W  shared register contents

Behaviour:
- Reset (sync, active-high, one clock; highest priority over every load) sets state=IDLE, grant=0, owner=0, rr pointer ptr=0, q=0. ack and wr_en are 0 while reset is high, regardless of state.
- Arbitration function: winner = first set bit of a candidate vector, scanning cyclically from index ptr upward, wrapping N-1→0.
- FSM states: IDLE, BUSY, LOCKED.
- IDLE:
  - grant=0, ack=0.
  - If |req: grant<=onehot(winner(req)), state<=BUSY.
- BUSY:
  - ack[owner]=req[owner]; wr_en=|ack; q<=wdata[owner] at the edge when wr_en=1.
  - If lock[owner]=1: state<=LOCKED; grant and ptr unchanged.
  - Else ptr<=owner+1 mod N, and:
    - if |(req & ~grant): grant<=onehot(winner(req & ~grant)) computed with the new ptr, stay BUSY;
    - else grant<=0, state<=IDLE.
  - Sustained throughput is 1 write/cycle with rotating owners.
- LOCKED:
  - ack[owner]=req[owner]; a write occurs only when req[owner]=1.
  - Owner without req holds the grant with no write and q unchanged.
  - Other requesters wait regardless of their req.
  - If lock[owner]=0: release. A write still occurs this cycle if req[owner]=1. Then apply the BUSY non-lock transition (ptr advance, re-arbitrate among others, or IDLE).
- Latency: req rising in IDLE at cycle n → grant at n+1 → ack and wr_en at n+1 → q updated at n+2.
- Handshake:
  - Requester must keep req and wdata stable until ack.
  - Requester deasserts req, or presents the next data, on the edge where ack=1.
  - Dropping req before ack is allowed. No write occurs, and if the owner is not locked, the grant moves on per the BUSY transition.
- Simultaneous events:
  - The current owner is excluded from re-arbitration the cycle after its unlocked write, for fairness.
  - lock on a non-owner is ignored.
  - Max wait for any requester without locks is N-1 grants.
- Reset mid-write: pending write is discarded; q=0 on the next cycle.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=2'd0, BUSY=2'd1, LOCKED=2'd2)
  - default N/W constants
- One sub-module is natural: flopr_en (W-bit register; ports clk, reset, En, d, q; sync active-high reset priority over En).
- The arbiter instantiates it with En=wr_en and d=wdata[owner].
- The round-robin winner function stays local to the arbiter.

Test Plan:
1. Reset: hold reset=1 for 2 cycles with req=4'b1111 → grant=0, ack=0, wr_en=0, q=4'h0; first grant after release is grant=4'b0001.
2. Single request: req=4'b0100, wdata[2]=4'b1011 at cycle 1 → grant=4'b0100 and ack=4'b0100 in cycle 2; q=4'b1011 in cycle 3; state returns to IDLE.
3. Round-robin: all req=4'b1111 with data 1,2,3,4, each dropped on its ack → grants 0001,0010,0100,1000 on consecutive cycles; q sequence 1,2,3,4; then IDLE.
4. Lock: req0 lock0=1 for 3 writes (data A,B,C) while req1=1 waiting → ack1=0 throughout; q=A,B,C. Then lock0=0 with final write D → grant=4'b0010 next cycle, q=D then req1 data.
5. Locked idle owner: in LOCKED, req0=0 and lock0=1 for 4 cycles with req2=1 → wr_en=0, q unchanged, grant=4'b0001 held. Then lock0=0 → grant=4'b0100 next cycle.
6. Reset mid-operation: assert reset in the BUSY cycle with ack[1]=1 and wdata=4'hF → q=4'h0 (not F), grant=0 at the next edge.
